// File: rtl/eight_bit_sub_add.sv
// Registered 8-bit ripple adder/subtractor with carry/borrow in and out, 1-cycle latency.
// Define EIGHT_BIT_SUB_ADD_FLAGS_EN to add registered ZERO and OVF (signed overflow) outputs.

module eight_bit_sub_add_cell (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module eight_bit_sub_add (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       IN_VALID,
   input  logic       SUB_ADD,
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       B_CIN,
   output logic [7:0] D_S,
   output logic       B_COUT,
   output logic       OUT_VALID
`ifdef EIGHT_BIT_SUB_ADD_FLAGS_EN
   ,
   output logic       ZERO,
   output logic       OVF
`endif
);

   logic [7:0] w_b_x;
   logic [7:0] w_sum;
   logic [8:0] w_carry;
   logic       w_b_cout;

   logic [7:0] r_d_s;
   logic       r_b_cout;
   logic       r_out_valid;

   // Subtract is A + ~B + ~borrow_in; the borrow out is the inverted final carry.
   assign w_b_x      = B ^ {8{SUB_ADD}};
   assign w_carry[0] = B_CIN ^ SUB_ADD;
   assign w_b_cout   = w_carry[8] ^ SUB_ADD;

   genvar g;
   generate
      for (g = 0; g < 8; g++) begin : g_chain
         eight_bit_sub_add_cell u_cell (
            .i_a (A[g]),
            .i_b (w_b_x[g]),
            .i_c (w_carry[g]),
            .o_s (w_sum[g]),
            .o_c (w_carry[g+1])
         );
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_d_s       <= 8'h00;
         r_b_cout    <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= IN_VALID;
         if (IN_VALID) begin
            r_d_s    <= w_sum;
            r_b_cout <= w_b_cout;
         end
      end
   end

   assign D_S       = r_d_s;
   assign B_COUT    = r_b_cout;
   assign OUT_VALID = r_out_valid;

`ifdef EIGHT_BIT_SUB_ADD_FLAGS_EN
   logic r_zero;
   logic r_ovf;

   // Carry into vs. out of the sign bit differs exactly on signed overflow, for both modes.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_zero <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (IN_VALID) begin
         r_zero <= (w_sum == 8'h00);
         r_ovf  <= w_carry[8] ^ w_carry[7];
      end
   end

   assign ZERO = r_zero;
   assign OVF  = r_ovf;
`endif

endmodule

// File: tb/tb_eight_bit_sub_add.sv
// Scoreboard bench for eight_bit_sub_add: directed vectors plus randomized stream with resets.

module tb_eight_bit_sub_add;

   logic       CLK;
   logic       RST_N;
   logic       IN_VALID;
   logic       SUB_ADD;
   logic [7:0] A;
   logic [7:0] B;
   logic       B_CIN;
   logic [7:0] D_S;
   logic       B_COUT;
   logic       OUT_VALID;
`ifdef EIGHT_BIT_SUB_ADD_FLAGS_EN
   logic       ZERO;
   logic       OVF;
`endif

   // Entry layout: {ds[7:0], cout, zero, ovf}
   logic [10:0] exp_q[$];
   int          chk_cnt  = 0;
   int          fail_cnt = 0;
   bit          done     = 0;

   eight_bit_sub_add dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .IN_VALID  (IN_VALID),
      .SUB_ADD   (SUB_ADD),
      .A         (A),
      .B         (B),
      .B_CIN     (B_CIN),
      .D_S       (D_S),
      .B_COUT    (B_COUT),
      .OUT_VALID (OUT_VALID)
`ifdef EIGHT_BIT_SUB_ADD_FLAGS_EN
      ,
      .ZERO      (ZERO),
      .OVF       (OVF)
`endif
   );

   // ---------------- clock ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- reference model ----------------
   function automatic logic [10:0] model(input bit sub, input int a, input int b, input int c);
      int res, sa, sb, sres;
      logic [7:0] ds;
      logic cout, z, o;
      sa = (a > 127) ? a - 256 : a;
      sb = (b > 127) ? b - 256 : b;
      if (sub) begin
         res  = a - b - c;
         cout = (a < b + c);
         sres = sa - sb - c;
      end else begin
         res  = a + b + c;
         cout = (res > 255);
         sres = sa + sb + c;
      end
      ds = 8'((res % 256 + 256) % 256);
      z  = (ds == 8'd0);
      o  = (sres > 127) || (sres < -128);
      return {ds, cout, z, o};
   endfunction

   task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got ds=%0d cout=%b z=%b o=%b, required ds=%0d cout=%b z=%b o=%b",
                  nm, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input bit rst_n, input bit v, input bit sub, input logic [7:0] a,
                        input logic [7:0] b, input bit c);
      @(posedge CLK);
      #1;
      RST_N    = rst_n;
      IN_VALID = v;
      SUB_ADD  = sub;
      A        = a;
      B        = b;
      B_CIN    = c;
      if (v && rst_n) exp_q.push_back(model(sub, int'(a), int'(b), int'(c)));
   endtask

   // ---------------- monitor ----------------
   logic [10:0] hold;
   logic [10:0] act;
   bit          cap, rst;
   logic [10:0] e;

   initial begin
      hold = '0;
      forever begin
         @(posedge CLK);
         cap = IN_VALID && RST_N;
         rst = !RST_N;
         @(negedge CLK);
         if (done) break;
`ifdef EIGHT_BIT_SUB_ADD_FLAGS_EN
         act = {D_S, B_COUT, ZERO, OVF};
`else
         act = {D_S, B_COUT, 2'b00};
`endif
         chk_cnt++;
         if (OUT_VALID !== cap) begin
            fail_cnt++;
            $display("FAIL out_valid: got %b, required %b", OUT_VALID, cap);
         end
         if (rst) begin
            hold = '0;
            chk("reset_state", act, hold);
         end else if (cap) begin
            if (exp_q.size() == 0) begin
               chk_cnt++;
               fail_cnt++;
               $display("FAIL scoreboard_empty: got output, required none");
            end else begin
               e = exp_q.pop_front();
`ifndef EIGHT_BIT_SUB_ADD_FLAGS_EN
               e[1:0] = 2'b00;
`endif
               hold = e;
               chk("result", act, e);
            end
         end else begin
            chk("hold", act, hold);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      RST_N = 1'b0; IN_VALID = 1'b1; SUB_ADD = 1'b0; A = 8'd7; B = 8'd9; B_CIN = 1'b0;
      drive(0, 1, 0, 8'd7, 8'd9, 0);
      drive(0, 0, 0, 8'd0, 8'd0, 0);
      // directed vectors
      drive(1, 1, 1, 8'd5,   8'd2,   0);
      drive(1, 1, 0, 8'd200, 8'd200, 0);
      drive(1, 1, 0, 8'd10,  8'd2,   0);
      drive(1, 0, 1, 8'd99,  8'd44,  1);
      drive(1, 0, 0, 8'd1,   8'd1,   0);
      drive(1, 1, 1, 8'd0,   8'd0,   1);
      drive(1, 1, 1, 8'd2,   8'd5,   0);
      drive(1, 1, 0, 8'd127, 8'd1,   0);
      drive(1, 1, 0, 8'd255, 8'd1,   0);
      drive(1, 1, 1, 8'd128, 8'd1,   0);
      drive(1, 1, 0, 8'd255, 8'd255, 1);
      // reset mid-stream with an op presented in the reset cycle
      drive(1, 1, 0, 8'd30,  8'd40,  1);
      drive(0, 1, 1, 8'd90,  8'd3,   0);
      drive(1, 1, 1, 8'd90,  8'd3,   0);
      drive(1, 1, 0, 8'd17,  8'd4,   1);
      // randomized stream
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
               8'($urandom), 8'($urandom), 1'($urandom));
      end
      drive(1, 0, 0, 8'd0, 8'd0, 0);
      drive(1, 0, 0, 8'd0, 8'd0, 0);
      drive(1, 0, 0, 8'd0, 8'd0, 0);
      @(posedge CLK);
      @(negedge CLK);
      done = 1;
      chk_cnt++;
      if (exp_q.size() != 0) begin
         fail_cnt++;
         $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/eight_bit_sub_add.md
EIGHT_BIT_SUB_ADD -- requirements
Module: eight_bit_sub_add

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 8 bits.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  synchronous active-low reset, sampled on the CLK rising edge.
REQ-005 IN_VALID  input  1  qualifies A, B, B_CIN and SUB_ADD for capture.
REQ-006 SUB_ADD  input  1  operation select: 1 = subtract, 0 = add.
REQ-007 A  input  8  unsigned minuend / addend.
REQ-008 B  input  8  unsigned subtrahend / addend.
REQ-009 B_CIN  input  1  carry-in when adding; borrow-in when subtracting.
REQ-010 D_S  output  8  registered difference or sum.
REQ-011 B_COUT  output  1  registered carry-out when adding; borrow-out when subtracting.
REQ-012 OUT_VALID  output  1  high for one cycle per captured operation.

Function
REQ-013 Add (SUB_ADD=0): {B_COUT,D_S} SHALL equal A + B + B_CIN, computed as a 9-bit unsigned sum.
REQ-014 Subtract (SUB_ADD=1): D_S SHALL equal (A - B - B_CIN) mod 256.
REQ-015 Subtract: B_COUT SHALL be 1 exactly when A < B + B_CIN (borrow), otherwise 0.
REQ-016 The datapath SHALL be an 8-stage ripple chain of 1-bit full-adder/subtractor cells: B is XOR-ed with SUB_ADD, and the carry polarity is inverted at the chain input and output in subtract mode.
REQ-017 Latency SHALL be 1 cycle: a CLK edge with IN_VALID=1 registers the result into D_S and B_COUT, and sets OUT_VALID=1 after that edge.
REQ-018 A CLK edge with IN_VALID=0 SHALL hold D_S and B_COUT and clear OUT_VALID.
REQ-019 Back-to-back IN_VALID SHALL be accepted every cycle; there is no backpressure.
REQ-020 Wrap-around: results SHALL be truncated to 8 bits with no saturation; overflow is reported only through B_COUT (and OVF when enabled).
REQ-021 A change to SUB_ADD between operations SHALL need no idle cycle.

Reset
REQ-022 On a CLK edge with RST_N=0, D_S SHALL become 0x00, B_COUT 0 and OUT_VALID 0, whatever IN_VALID is.
REQ-023 Reset SHALL take priority over capture; an operation presented in a reset cycle SHALL be discarded.
REQ-024 Reset asserted mid-stream SHALL clear outputs on that edge, and capture SHALL resume on the first edge with RST_N=1.

Configuration
REQ-025 With macro EIGHT_BIT_SUB_ADD_FLAGS_EN defined, the block SHALL add two registered outputs, updated with D_S and reset to 0:
- ZERO (1 bit): 1 when the result D_S is 0x00.
- OVF (1 bit): two's-complement signed overflow of the operation.
REQ-026 Without EIGHT_BIT_SUB_ADD_FLAGS_EN, the ZERO and OVF ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 SUB_ADD=1, A=5, B=2, B_CIN=0, IN_VALID=1 -> next cycle D_S=3, B_COUT=0, OUT_VALID=1.
REQ-028 SUB_ADD=0, A=200, B=200, B_CIN=0 -> D_S=144, B_COUT=1; with flags enabled, OVF=0 and ZERO=0.
REQ-029 SUB_ADD=0, A=10, B=2, B_CIN=0 -> D_S=12, B_COUT=0; then IN_VALID=0 -> D_S holds at 12 and OUT_VALID=0.
REQ-030 SUB_ADD=1, A=0, B=0, B_CIN=1 -> D_S=255, B_COUT=1; A=2, B=5, B_CIN=0 -> D_S=253, B_COUT=1.
REQ-031 SUB_ADD=0, A=127, B=1, flags enabled -> D_S=128, OVF=1; A=255, B=1 -> D_S=0, B_COUT=1, ZERO=1.
REQ-032 Stream of valid operations with RST_N=0 for one cycle -> D_S=0, B_COUT=0, OUT_VALID=0 after that edge; the next valid operation is produced correctly 1 cycle after RST_N returns high.
